// File: rtl/vga_capture.sv
// VGA sink: recovers pixel position from HSYNC/VSYNC, tracks timing lock and writes active pixels to a frame buffer.
// Optional VGA_CAPTURE_CHECKSUM_EN adds a per-frame 24-bit sum of written pixel words on frame_sum.
module vga_capture #(
    parameter int H_TOTAL  = 800,
    parameter int V_TOTAL  = 525,
    parameter int H_START  = 144,
    parameter int H_ACTIVE = 640,
    parameter int V_START  = 31,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19
) (
    input  logic              vga_clk,
    input  logic              rst,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic [3:0]        r_in,
    input  logic [3:0]        g_in,
    input  logic [3:0]        b_in,
    input  logic              capture_en,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [11:0]       wr_data,
    output logic              locked,
    output logic              frame_done,
    output logic              timing_err,
    output logic [23:0]       frame_sum
);

    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0]     H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]     H_MAX    = HW'(H_TOTAL);
    localparam logic [HW-1:0]     H_ACT_LO = HW'(H_START);
    localparam logic [HW-1:0]     H_ACT_HI = HW'(H_START + H_ACTIVE);
    localparam logic [VW-1:0]     V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]     V_MAX    = VW'(V_TOTAL);
    localparam logic [VW-1:0]     V_ACT_LO = VW'(V_START);
    localparam logic [VW-1:0]     V_ACT_HI = VW'(V_START + V_ACTIVE);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t            state;
    logic              hs_s1, vs_s1;
    logic [3:0]        r_s1, g_s1, b_s1;
    logic [HW-1:0]     hpos;
    logic [VW-1:0]     vline;
    logic              vs_pend;
    logic              cap_frame;
    logic [ADDR_W-1:0] pix_addr;

    logic line_start, vs_start, frame_start;
    logic line_err, frame_err, violation;
    logic pix_active, do_write, last_write;

    // Edges are taken between the raw pin and its registered copy, so hpos lines up with the s1 pixel.
    assign line_start  = hs_s1 & ~hsync_in;
    assign vs_start    = vsync_in & ~vs_s1;
    assign frame_start = line_start & (vs_pend | vs_start);

    assign line_err  = line_start ? (hpos != H_LAST) : (hpos == H_LAST);
    assign frame_err = frame_start & (vline != V_LAST);
    assign violation = (state != SEARCH) & (line_err | frame_err);

    assign pix_active = (hpos >= H_ACT_LO) && (hpos < H_ACT_HI) &&
                        (vline >= V_ACT_LO) && (vline < V_ACT_HI);
    assign do_write   = pix_active & cap_frame & ~violation;
    assign last_write = wr_en & (wr_addr == LAST_ADDR) & ~violation;

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            hs_s1      <= 1'b0;
            vs_s1      <= 1'b0;
            r_s1       <= '0;
            g_s1       <= '0;
            b_s1       <= '0;
            hpos       <= '0;
            vline      <= '0;
            vs_pend    <= 1'b0;
            state      <= SEARCH;
            locked     <= 1'b0;
            timing_err <= 1'b0;
            cap_frame  <= 1'b0;
            pix_addr   <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
        end else begin
            hs_s1 <= hsync_in;
            vs_s1 <= vsync_in;
            r_s1  <= r_in;
            g_s1  <= g_in;
            b_s1  <= b_in;

            if (line_start)
                hpos <= '0;
            else if (hpos != H_MAX)
                hpos <= hpos + HW'(1);

            if (line_start) begin
                if (vs_pend | vs_start) begin
                    vline   <= '0;
                    vs_pend <= 1'b0;
                end else if (vline != V_MAX) begin
                    vline <= vline + VW'(1);
                end
            end else if (vs_start) begin
                vs_pend <= 1'b1;
            end

            timing_err <= violation;
            case (state)
                SEARCH: begin
                    if (frame_start)
                        state <= MEASURE;
                end
                MEASURE: begin
                    if (violation) begin
                        state <= SEARCH;
                    end else if (frame_start) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (violation) begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                    end
                end
                default: begin
                    state  <= SEARCH;
                    locked <= 1'b0;
                end
            endcase

            // Capture is armed only on a clean frame start while locked; any violation aborts it.
            if (violation)
                cap_frame <= 1'b0;
            else if (frame_start && state == LOCKED)
                cap_frame <= capture_en;

            if (frame_start)
                pix_addr <= '0;
            else if (pix_active)
                pix_addr <= pix_addr + ADDR_W'(1);

            wr_en <= do_write;
            if (do_write) begin
                wr_addr <= pix_addr;
                wr_data <= {b_s1, g_s1, r_s1};
            end

            frame_done <= last_write;
        end
    end

`ifdef VGA_CAPTURE_CHECKSUM_EN
    logic [23:0] sum_acc;

    // frame_sum is loaded on the same edge that raises frame_done, so both are valid together.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            sum_acc   <= '0;
            frame_sum <= '0;
        end else begin
            if (frame_start)
                sum_acc <= '0;
            else if (wr_en)
                sum_acc <= sum_acc + {12'd0, wr_data};
            if (last_write)
                frame_sum <= sum_acc + {12'd0, wr_data};
        end
    end
`else
    assign frame_sum = '0;
`endif

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture on a scaled-down raster: directed frames with lock, arming, line/frame faults, reset and checksum.
module tb_vga_capture;

    localparam int H_TOTAL  = 24;
    localparam int V_TOTAL  = 14;
    localparam int H_START  = 6;
    localparam int H_ACTIVE = 12;
    localparam int V_START  = 4;
    localparam int V_ACTIVE = 6;
    localparam int ADDR_W   = 19;
    localparam int HS_W     = 2;
    localparam int VS_W     = 1;
    localparam int LAST     = H_ACTIVE * V_ACTIVE - 1;

    logic              vga_clk;
    logic              rst;
    logic              hsync_in;
    logic              vsync_in;
    logic [3:0]        r_in, g_in, b_in;
    logic              capture_en;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [11:0]       wr_data;
    logic              locked;
    logic              frame_done;
    logic              timing_err;
    logic [23:0]       frame_sum;

    vga_capture #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL),
        .H_START (H_START),
        .H_ACTIVE(H_ACTIVE),
        .V_START (V_START),
        .V_ACTIVE(V_ACTIVE),
        .ADDR_W  (ADDR_W)
    ) dut (
        .vga_clk   (vga_clk),
        .rst       (rst),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .r_in      (r_in),
        .g_in      (g_in),
        .b_in      (b_in),
        .capture_en(capture_en),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .locked    (locked),
        .frame_done(frame_done),
        .timing_err(timing_err),
        .frame_sum (frame_sum)
    );

    // clock / reset
    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    // scoreboard state
    logic [ADDR_W+11:0] exp_q[$];
    logic [23:0]        exp_sum_q[$];
    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        check(name, {wr_en, wr_addr, wr_data, locked, frame_done, timing_err, frame_sum}, 64'd0);
    endtask

    // monitor: pops expected writes and checksums as the DUT presents them
    always @(negedge vga_clk) begin
        logic [ADDR_W+11:0] e;
        if (!rst) begin
            if (wr_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: actual addr=%0d data=%0h expected no write", wr_addr, wr_data);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(wr_addr), 64'(e[ADDR_W+11:12]));
                    check("wr_data", 64'(wr_data), 64'(e[11:0]));
                end
            end
            if (frame_done === 1'b1) begin
                done_cnt++;
                if (exp_sum_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame_done: actual pulse expected none (sum=%0h)", frame_sum);
                end else begin
                    check("frame_sum", 64'(frame_sum), 64'(exp_sum_q.pop_front()));
                end
            end
            if (timing_err === 1'b1)
                err_cnt++;
        end
    end

    // driver: one source frame; optional short line, reset point, mid-frame capture_en raise, constant pixel
    task automatic drive_frame(input int n_lines, input int short_line, input bit exp_cap,
                               input int rst_v, input int rst_h, input int raise_v, input bit const_pix);
        bit          cap;
        logic [23:0] sum;
        logic [11:0] px;
        int          len, row, col;
        bit          act;
        cap = exp_cap;
        sum = '0;
        for (int v = 0; v < n_lines; v++) begin
            len = (v == short_line) ? H_TOTAL - 1 : H_TOTAL;
            for (int h = 0; h < len; h++) begin
                @(posedge vga_clk);
                #1;
                if (v == rst_v && h == rst_h) begin
                    rst = 1'b1;
                    #1;
                    check_outputs_zero("mid_frame_reset_outputs");
                    exp_q.delete();
                    cap = 1'b0;
                end
                if (v == rst_v && h == rst_h + 3)
                    rst = 1'b0;
                if (v == raise_v && h == 0)
                    capture_en = 1'b1;
                hsync_in = (h >= HS_W);
                vsync_in = (v < VS_W);
                row = v - V_START;
                col = h - H_START;
                act = (h >= H_START) && (h < H_START + H_ACTIVE) &&
                      (v >= V_START) && (v < V_START + V_ACTIVE);
                if (!act)
                    px = 12'hA5C;
                else if (const_pix)
                    px = 12'h001;
                else
                    px = 12'((row * H_ACTIVE + col) & 32'hFFF);
                {b_in, g_in, r_in} = px;
                if (act && cap) begin
                    exp_q.push_back({ADDR_W'(row * H_ACTIVE + col), px});
                    sum = sum + {12'd0, px};
                    if (row * H_ACTIVE + col == LAST) begin
`ifdef VGA_CAPTURE_CHECKSUM_EN
                        exp_sum_q.push_back(sum);
`else
                        exp_sum_q.push_back(24'd0);
`endif
                    end
                end
            end
            if (v == short_line)
                cap = 1'b0;
        end
    endtask

    task automatic end_frame(input string tag, input bit exp_locked, input int exp_done, input int exp_err);
        @(negedge vga_clk);
        check({tag, "_locked"}, 64'(locked), 64'(exp_locked));
        check({tag, "_frame_done_count"}, 64'(done_cnt), 64'(exp_done));
        check({tag, "_timing_err_count"}, 64'(err_cnt), 64'(exp_err));
        check({tag, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_pending_sums"}, 64'(exp_sum_q.size()), 64'd0);
    endtask

    initial begin
        rst        = 1'b0;
        hsync_in   = 1'b1;
        vsync_in   = 1'b0;
        r_in       = '0;
        g_in       = '0;
        b_in       = '0;
        capture_en = 1'b1;
        #2 rst = 1'b1;
        #2 check_outputs_zero("reset_outputs");
        repeat (3) @(posedge vga_clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge vga_clk);

        // nominal lock and capture
        drive_frame(V_TOTAL, -1, 1'b0, -1, -1, -1, 1'b0); end_frame("f1", 1'b0, 0, 0);
        drive_frame(V_TOTAL, -1, 1'b0, -1, -1, -1, 1'b0); end_frame("f2", 1'b1, 0, 0);
        drive_frame(V_TOTAL, -1, 1'b1, -1, -1, -1, 1'b0); end_frame("f3", 1'b1, 1, 0);
        drive_frame(V_TOTAL, -1, 1'b1, -1, -1, -1, 1'b0); end_frame("f4", 1'b1, 2, 0);

        // arming: enable raised mid-frame is ignored until the next frame start
        capture_en = 1'b0;
        drive_frame(V_TOTAL, -1, 1'b0, -1, -1, 6, 1'b0);  end_frame("f5", 1'b1, 2, 0);
        drive_frame(V_TOTAL, -1, 1'b1, -1, -1, -1, 1'b0); end_frame("f6", 1'b1, 3, 0);

        // line fault: short line 6 aborts the frame, then two clean frames to relock
        drive_frame(V_TOTAL, 6, 1'b1, -1, -1, -1, 1'b0);  end_frame("f7", 1'b0, 3, 1);
        drive_frame(V_TOTAL, -1, 1'b0, -1, -1, -1, 1'b0); end_frame("f8", 1'b0, 3, 1);
        drive_frame(V_TOTAL, -1, 1'b0, -1, -1, -1, 1'b0); end_frame("f9", 1'b1, 3, 1);
        drive_frame(V_TOTAL, -1, 1'b1, -1, -1, -1, 1'b0); end_frame("f10", 1'b1, 4, 1);

        // frame fault: one line short per frame, flagged at the early frame start
        drive_frame(V_TOTAL - 1, -1, 1'b1, -1, -1, -1, 1'b0); end_frame("f11", 1'b1, 5, 1);
        drive_frame(V_TOTAL, -1, 1'b0, -1, -1, -1, 1'b0);     end_frame("f12", 1'b0, 5, 2);
        drive_frame(V_TOTAL, -1, 1'b0, -1, -1, -1, 1'b0);     end_frame("f13", 1'b0, 5, 2);
        drive_frame(V_TOTAL, -1, 1'b0, -1, -1, -1, 1'b0);     end_frame("f14", 1'b1, 5, 2);
        drive_frame(V_TOTAL, -1, 1'b1, -1, -1, -1, 1'b0);     end_frame("f15", 1'b1, 6, 2);

        // reset in the middle of an armed frame
        drive_frame(V_TOTAL, -1, 1'b1, 6, 10, -1, 1'b0);  end_frame("f16", 1'b0, 6, 2);
        drive_frame(V_TOTAL, -1, 1'b0, -1, -1, -1, 1'b0); end_frame("f17", 1'b0, 6, 2);
        drive_frame(V_TOTAL, -1, 1'b0, -1, -1, -1, 1'b0); end_frame("f18", 1'b1, 6, 2);
        drive_frame(V_TOTAL, -1, 1'b1, -1, -1, -1, 1'b0); end_frame("f19", 1'b1, 7, 2);

        // constant pixel 0x001: checksum equals pixel count when enabled
        drive_frame(V_TOTAL, -1, 1'b1, -1, -1, -1, 1'b1); end_frame("f20", 1'b1, 8, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
